// File: rtl/scan_host_pkg.sv
// ============================================================================
// Module   : scan_host_pkg
// Purpose  : Shared definitions for the scan_host tester-side scan master:
//            command op codes, controller state encoding and counter-width
//            helpers.
// Ports    : none (package)
// Config   : SCAN_HOST_PARITY_EN (used by scan_host, not referenced here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_host_pkg;

  // Command op codes carried on cmd_op
  localparam logic OP_SHIFT = 1'b0;
  localparam logic OP_RUN   = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Bits needed to count 0..n-1 (never less than one bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_host_shreg.sv
// ============================================================================
// Module   : scan_host_shreg
// Purpose  : CHAIN_LEN-bit pattern/capture shift register for scan_host.
//            Loaded with the outgoing pattern at command acceptance; every
//            shift cycle it moves toward the LSB (exposing the next sin bit)
//            while the chain's sout is inserted at the MSB. After CHAIN_LEN
//            shifts it holds the unloaded chain word with bit k = k-th bit
//            that left the chain.
// Ports    : clk_i       clock
//            reset_i     asynchronous active-high reset
//            load_i      load pat_i (takes priority over shift_i)
//            pat_i       parallel load value
//            shift_i     shift one position
//            sout_i      serial bit captured into the MSB
//            data_o      current register contents
//            next_sin_o  bit to drive on sin in the following shift cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_host_shreg
  import scan_host_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] pat_i,
  input  logic                 shift_i,
  input  logic                 sout_i,
  output logic [CHAIN_LEN-1:0] data_o,
  output logic                 next_sin_o
);

  logic [CHAIN_LEN-1:0] data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= pat_i;
    end else if (shift_i) begin
      data_q <= {sout_i, data_q[CHAIN_LEN-1:1]};
    end
  end

  // data_q[0] is the bit currently on sin (driven by the top's register),
  // so the bit that follows it is data_q[1].
  assign next_sin_o = data_q[1];
  assign data_o     = data_q;

endmodule

`default_nettype wire

// File: rtl/scan_host.sv
// ============================================================================
// Module   : scan_host
// Purpose  : Tester-side scan chain master. Accepts SHIFT (load new pattern,
//            unload old one) and RUN (N functional cycles) commands over a
//            val/rdy port and returns exactly one response per command.
//            One command in flight at a time.
// Ports    : clk_i         clock; scan pins change on its rising edge
//            reset_i       asynchronous active-high reset
//            cmd_val_i     command valid
//            cmd_rdy_o     command ready (only in IDLE)
//            cmd_op_i      0 = SHIFT, 1 = RUN
//            cmd_pat_i     SHIFT pattern, bit 0 enters sin first
//            cmd_cycles_i  RUN length in functional cycles
//            resp_val_o    response valid
//            resp_rdy_i    response ready
//            resp_data_o   SHIFT: unloaded chain word; RUN: zero
//            sen_o         scan enable to DUT
//            scan_ce_o     chain clock enable to DUT
//            sin_o         serial data into the chain
//            sout_i        serial data from the chain's last flop
//            resp_par_o    XOR of resp_data (SCAN_HOST_PARITY_EN only)
// Config   : SCAN_HOST_PARITY_EN - adds resp_par_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_host
  import scan_host_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cmd_val_i,
  output logic                 cmd_rdy_o,
  input  logic                 cmd_op_i,
  input  logic [CHAIN_LEN-1:0] cmd_pat_i,
  input  logic [CNT_W-1:0]     cmd_cycles_i,
  output logic                 resp_val_o,
  input  logic                 resp_rdy_i,
  output logic [CHAIN_LEN-1:0] resp_data_o,
  output logic                 sen_o,
  output logic                 scan_ce_o,
  output logic                 sin_o,
  input  logic                 sout_i
`ifdef SCAN_HOST_PARITY_EN
  ,
  output logic                 resp_par_o
`endif
);

  // One counter serves both SHIFT (0..CHAIN_LEN-1) and RUN (0..N-1)
  localparam int SH_W = cnt_width(CHAIN_LEN);
  localparam int CW   = max_int(CNT_W, SH_W);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CNT_W-1:0]     cycles_q;
  logic                 cmd_rdy_q;
  logic                 resp_val_q;
  logic                 sen_q;
  logic                 ce_q;
  logic                 sin_q;

  logic                 w_accept;
  logic                 w_shift;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_shift_last;
  logic                 w_run_last;
  logic [CHAIN_LEN-1:0] w_load_pat;
  logic [CHAIN_LEN-1:0] w_sh_data;
  logic                 w_next_sin;

  assign w_accept     = (state_q == IDLE) && cmd_val_i && cmd_rdy_q;
  assign w_shift      = (state_q == SHIFT);
  assign w_cnt_inc    = cnt_q + CW'(1);
  assign w_shift_last = (cnt_q == CW'(CHAIN_LEN - 1));
  assign w_run_last   = (w_cnt_inc == CW'(cycles_q));

  // RUN loads zeros so the register doubles as the all-zero RUN response
  assign w_load_pat   = (cmd_op_i == OP_SHIFT) ? cmd_pat_i : '0;

  scan_host_shreg #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_shreg (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (w_accept),
    .pat_i      (w_load_pat),
    .shift_i    (w_shift),
    .sout_i     (sout_i),
    .data_o     (w_sh_data),
    .next_sin_o (w_next_sin)
  );

  // Controller FSM with registered scan pins and handshake outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cycles_q   <= '0;
      cmd_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      sen_q      <= 1'b0;
      ce_q       <= 1'b0;
      sin_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            cmd_rdy_q <= 1'b0;
            cnt_q     <= '0;
            cycles_q  <= cmd_cycles_i;
            if (cmd_op_i == OP_SHIFT) begin
              state_q <= SHIFT;
              sen_q   <= 1'b1;
              ce_q    <= 1'b1;
              sin_q   <= cmd_pat_i[0];
            end else if (cmd_cycles_i == '0) begin
              // Zero-length RUN: respond without touching the chain
              state_q    <= RESP;
              resp_val_q <= 1'b1;
            end else begin
              state_q <= RUN;
              ce_q    <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (w_shift_last) begin
            // This edge shifts the last sout into the capture register
            state_q    <= RESP;
            sen_q      <= 1'b0;
            ce_q       <= 1'b0;
            sin_q      <= 1'b0;
            cnt_q      <= '0;
            resp_val_q <= 1'b1;
          end else begin
            cnt_q <= w_cnt_inc;
            sin_q <= w_next_sin;
          end
        end

        RUN: begin
          if (w_run_last) begin
            state_q    <= RESP;
            ce_q       <= 1'b0;
            cnt_q      <= '0;
            resp_val_q <= 1'b1;
          end else begin
            cnt_q <= w_cnt_inc;
          end
        end

        RESP: begin
          if (resp_rdy_i) begin
            state_q    <= IDLE;
            resp_val_q <= 1'b0;
            cmd_rdy_q  <= 1'b1;
          end
        end

        default: begin
          state_q    <= IDLE;
          cmd_rdy_q  <= 1'b1;
          resp_val_q <= 1'b0;
          sen_q      <= 1'b0;
          ce_q       <= 1'b0;
          sin_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCAN_HOST_PARITY_EN
  logic                 par_q;
  logic [CHAIN_LEN-1:0] w_capture;

  // Same word the shift register holds after the final shift edge
  assign w_capture = {sout_i, w_sh_data[CHAIN_LEN-1:1]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      par_q <= 1'b0;
    end else if (w_shift && w_shift_last) begin
      par_q <= ^w_capture;
    end else if (w_accept) begin
      par_q <= 1'b0;
    end
  end

  assign resp_par_o = par_q;
`endif

  assign cmd_rdy_o   = cmd_rdy_q;
  assign resp_val_o  = resp_val_q;
  assign resp_data_o = w_sh_data;
  assign sen_o       = sen_q;
  assign scan_ce_o   = ce_q;
  assign sin_o       = sin_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_host.sv
// ============================================================================
// Module   : tb_scan_host
// Purpose  : Self-checking bench for scan_host with a 16-flop chain model.
//            Expected responses are computed from the command stream alone
//            (unload_word tracks what the chain must hold) and queued; a
//            negedge monitor pops and compares them when responses are taken.
// Config   : SCAN_HOST_PARITY_EN - also checks resp_par
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_val = 1'b0;
  logic        cmd_op = 1'b0;
  logic [15:0] cmd_pat = '0;
  logic [7:0]  cmd_cycles = '0;
  logic        resp_rdy = 1'b1;
  logic        cmd_rdy, resp_val, sen, scan_ce, sin, sout;
  logic [15:0] resp_data;
`ifdef SCAN_HOST_PARITY_EN
  logic        resp_par;
`endif

  scan_host #(.CHAIN_LEN(16), .CNT_W(8)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_val_i    (cmd_val),
    .cmd_rdy_o    (cmd_rdy),
    .cmd_op_i     (cmd_op),
    .cmd_pat_i    (cmd_pat),
    .cmd_cycles_i (cmd_cycles),
    .resp_val_o   (resp_val),
    .resp_rdy_i   (resp_rdy),
    .resp_data_o  (resp_data),
    .sen_o        (sen),
    .scan_ce_o    (scan_ce),
    .sin_o        (sin),
    .sout_i       (sout)
`ifdef SCAN_HOST_PARITY_EN
    ,
    .resp_par_o   (resp_par)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: f[0] <= sin, f[i] <= f[i-1], sout = f[15]
  logic [15:0] chain = '0;
  assign sout = chain[15];
  always @(posedge clk) if (scan_ce) chain <= {chain[14:0], sin};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        par;
    int          lat;
    bit          chk;
  } exp_t;
  exp_t sb[$];

  // Bit k = k-th bit the chain will emit on the next unload
  logic [15:0] unload_word = '0;

  int accept_cyc = 0;
  int hs_cyc = 0;
  int gap_q[$];
  bit rec_gaps = 1'b0;
  int sen_cnt = 0, ce_cnt = 0, run_ce_cnt = 0, viol = 0;
  logic resp_val_prev = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (sen) sen_cnt++;
      if (scan_ce) ce_cnt++;
      if (scan_ce && !sen) run_ce_cnt++;
      if ((sin && !sen) || (sen && !scan_ce) || (cmd_rdy && resp_val)) viol++;
      if (cmd_val && cmd_rdy) begin
        accept_cyc = cyc + 1;
        if (rec_gaps) gap_q.push_back(accept_cyc - hs_cyc);
      end
      if (resp_val && !resp_val_prev && sb.size() > 0) begin
        checks++;
        if (cyc - accept_cyc != sb[0].lat) begin
          failures++;
          $display("FAIL latency: got %0d cycles, required %0d", cyc - accept_cyc, sb[0].lat);
        end
      end
      if (resp_val && resp_rdy) begin
        hs_cyc = cyc + 1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: resp_data=%h with no command outstanding", resp_data);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            checks++;
            if (resp_data !== e.data) begin
              failures++;
              $display("FAIL resp_data: got %h required %h", resp_data, e.data);
            end
`ifdef SCAN_HOST_PARITY_EN
            checks++;
            if (resp_par !== e.par) begin
              failures++;
              $display("FAIL resp_par: got %b required %b", resp_par, e.par);
            end
`endif
          end
        end
      end
      resp_val_prev = resp_val;
    end else begin
      resp_val_prev = 1'b0;
    end
  end

  task automatic clear_counts();
    sen_cnt = 0; ce_cnt = 0; run_ce_cnt = 0;
  endtask

  task automatic issue(input logic op, input logic [15:0] pat, input logic [7:0] n, input bit chk);
    exp_t e;
    int g = 0;
    while (!cmd_rdy && g < 100) begin @(posedge clk); #1; g++; end
    checks++;
    if (!cmd_rdy) begin
      failures++;
      $display("FAIL issue_rdy: cmd_rdy=%b required 1", cmd_rdy);
      return;
    end
    if (op == 1'b0) begin
      e.data = unload_word; e.par = ^unload_word; e.lat = 16; e.chk = chk;
      unload_word = pat;
    end else begin
      e.data = '0; e.par = 1'b0; e.lat = int'(n); e.chk = chk;
      unload_word = unload_word >> n;
    end
    sb.push_back(e);
    cmd_val = 1'b1; cmd_op = op; cmd_pat = pat; cmd_cycles = n;
    @(posedge clk); #1;
    // Scramble command fields: the DUT must have latched them
    cmd_val = 1'b0; cmd_op = 1'($urandom); cmd_pat = 16'($urandom); cmd_cycles = 8'($urandom);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || !cmd_rdy) && g < 400) begin @(posedge clk); #1; g++; end
    checks++;
    if (sb.size() != 0 || !cmd_rdy) begin
      failures++;
      $display("FAIL drain: pending=%0d cmd_rdy=%b required pending=0 cmd_rdy=1", sb.size(), cmd_rdy);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_rdy, resp_val, sen, scan_ce, sin} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctl: rdy,val,sen,ce,sin=%b required 10000", {cmd_rdy, resp_val, sen, scan_ce, sin});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cmd_rdy, resp_val, sen, scan_ce, sin} !== 5'b10000 || resp_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_idle: rdy,val,sen,ce,sin=%b data=%h required 10000 0000",
               {cmd_rdy, resp_val, sen, scan_ce, sin}, resp_data);
    end
  endtask

  task automatic test_first_shift();
    clear_counts();
    issue(1'b0, 16'hA5C3, 8'd0, 1'b1);
    wait_drain();
    checks++;
    if (sen_cnt != 16 || ce_cnt != 16) begin
      failures++;
      $display("FAIL shift_len: sen=%0d ce=%0d cycles, required 16 16", sen_cnt, ce_cnt);
    end
  endtask

  task automatic test_shift_seq();
    issue(1'b0, 16'h1234, 8'd0, 1'b1);
    wait_drain();
    issue(1'b0, 16'h0001, 8'd0, 1'b1);
    wait_drain();
    issue(1'b0, 16'h5A5A, 8'd0, 1'b1);
    wait_drain();
  endtask

  task automatic test_run();
    clear_counts();
    issue(1'b1, 16'h0000, 8'd5, 1'b1);
    wait_drain();
    checks++;
    if (ce_cnt != 5 || run_ce_cnt != 5 || sen_cnt != 0) begin
      failures++;
      $display("FAIL run5: ce=%0d ce_nosen=%0d sen=%0d required 5 5 0", ce_cnt, run_ce_cnt, sen_cnt);
    end
    clear_counts();
    issue(1'b1, 16'h0000, 8'd0, 1'b1);
    wait_drain();
    checks++;
    if (ce_cnt != 0 || sen_cnt != 0) begin
      failures++;
      $display("FAIL run0: ce=%0d sen=%0d required 0 0", ce_cnt, sen_cnt);
    end
    // Unload after the RUN shows the zeros it clocked into the chain
    issue(1'b0, 16'h0F0F, 8'd0, 1'b1);
    wait_drain();
  endtask

  task automatic test_hold();
    logic [15:0] snap;
    int g = 0;
    int bad = 0;
    resp_rdy = 1'b0;
    issue(1'b0, 16'h3C3C, 8'd0, 1'b1);
    while (!resp_val && g < 40) begin @(posedge clk); #1; g++; end
    checks++;
    if (!resp_val) begin
      failures++;
      $display("FAIL hold_wait: resp_val=%b required 1", resp_val);
    end
    snap = resp_data;
    cmd_val = 1'b1; cmd_op = 1'b1; cmd_cycles = 8'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!resp_val || resp_data !== snap || cmd_rdy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
    end
    cmd_val = 1'b0;
    resp_rdy = 1'b1;
    wait_drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int g = 0;
    int seen_val = 0;
    clear_counts();
    while (!cmd_rdy && g < 100) begin @(posedge clk); #1; g++; end
    cmd_val = 1'b1; cmd_op = 1'b0; cmd_pat = 16'hFFFF;
    @(posedge clk); #1;
    cmd_val = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({sen, scan_ce, sin, resp_val, cmd_rdy} !== 5'b00001 || sen_cnt != 7) begin
      failures++;
      $display("FAIL reset_mid: sen,ce,sin,val,rdy=%b sen_cycles=%0d required 00001 7",
               {sen, scan_ce, sin, resp_val, cmd_rdy}, sen_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (resp_val) seen_val++;
    end
    checks++;
    if (seen_val != 0 || !cmd_rdy) begin
      failures++;
      $display("FAIL reset_abort: resp_val cycles=%0d cmd_rdy=%b required 0 1", seen_val, cmd_rdy);
    end
    // Chain contents unknown after the abort: reload without checking the unload
    issue(1'b0, 16'h6666, 8'd0, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] pats [3];
    exp_t e;
    int g;
    pats[0] = 16'h1111; pats[1] = 16'h2222; pats[2] = 16'h3333;
    gap_q.delete();
    rec_gaps = 1'b1;
    resp_rdy = 1'b1;
    cmd_val = 1'b1; cmd_op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      g = 0;
      while (!cmd_rdy && g < 100) begin @(posedge clk); #1; g++; end
      e.data = unload_word; e.par = ^unload_word; e.lat = 16; e.chk = 1'b1;
      sb.push_back(e);
      unload_word = pats[i];
      cmd_pat = pats[i];
      @(posedge clk); #1;
    end
    cmd_val = 1'b0;
    wait_drain();
    rec_gaps = 1'b0;
    checks++;
    if (gap_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d required 3", gap_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (gap_q[i] != 1) begin
          failures++;
          $display("FAIL b2b_gap%0d: handshake-to-accept=%0d cycles required 1", i, gap_q[i]);
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL pin_invariants: %0d violating cycles, required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_first_shift();
    test_shift_seq();
    test_run();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
